// File: rtl/uart_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_if : serial line, CPU-side byte handshake and status flags   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
interface uart_rx_if;
  logic       rx_en;
  logic       rx;
  logic       ack;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_err;
  logic       overrun_err;
  logic       busy_flag;

  modport master (
    output rx_en, rx, ack,
    input  data, data_valid, framing_err, overrun_err, busy_flag
  );

  modport slave (
    input  rx_en, rx, ack,
    output data, data_valid, framing_err, overrun_err, busy_flag
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx : 8N1 UART receiver, mid-bit sampling, valid/ack holding reg |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_rx #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int CLK_COUNT_BIT = CLK_FREQ / BAUD_RATE
) (
  input  wire      clk,
  input  wire      rst_n,
  uart_rx_if.slave bus
);

  localparam logic [31:0] C_FULL = 32'(CLK_COUNT_BIT - 1);
  localparam logic [31:0] C_HALF = 32'(CLK_COUNT_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_rx_m;
  logic        r_rx_s;
  logic [31:0] r_clk_count;
  logic [2:0]  r_bit_count;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_data_valid;
  logic        r_framing_err;
  logic        r_overrun_err;

  logic w_full;
  logic w_half;
  logic w_ack_ok;

  assign w_full   = (r_clk_count == C_FULL);
  assign w_half   = (r_clk_count == C_HALF);
  assign w_ack_ok = bus.ack & r_data_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rx_m        <= 1'b1;
      r_rx_s        <= 1'b1;
      r_clk_count   <= '0;
      r_bit_count   <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_data_valid  <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_rx_m <= bus.rx;
      r_rx_s <= r_rx_m;

      // Ack clears first; a same-cycle completion or error below overrides it.
      if (w_ack_ok) begin
        r_data_valid  <= 1'b0;
        r_framing_err <= 1'b0;
        r_overrun_err <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_clk_count <= '0;
          if (bus.rx_en && !r_rx_s) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_half) begin
            r_clk_count <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_state     <= S_DATA;
              r_bit_count <= '0;
            end
          end else begin
            r_clk_count <= r_clk_count + 32'd1;
          end
        end

        S_DATA: begin
          if (w_full) begin
            r_clk_count          <= '0;
            r_shift[r_bit_count] <= r_rx_s;
            if (r_bit_count == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_count <= r_bit_count + 3'd1;
            end
          end else begin
            r_clk_count <= r_clk_count + 32'd1;
          end
        end

        S_STOP: begin
          if (w_full) begin
            r_clk_count <= '0;
            if (r_rx_s) begin
              r_data       <= r_shift;
              r_data_valid <= 1'b1;
              if (r_data_valid && !bus.ack) begin
                r_overrun_err <= 1'b1;
              end
              r_state <= S_IDLE;
            end else begin
              r_framing_err <= 1'b1;
              r_state       <= S_BREAK;
            end
          end else begin
            r_clk_count <= r_clk_count + 32'd1;
          end
        end

        S_BREAK: begin
          r_clk_count <= '0;
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_clk_count <= '0;
        end
      endcase
    end
  end

  assign bus.data        = r_data;
  assign bus.data_valid  = r_data_valid;
  assign bus.framing_err = r_framing_err;
  assign bus.overrun_err = r_overrun_err;
  assign bus.busy_flag   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx : directed frames, byte scoreboard and status flag checks |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_uart_rx;

  localparam int P_CLK_FREQ = 3_200_000;
  localparam int P_BAUD     = 100_000;
  localparam int BIT        = 320;   // 32 clocks of 10 time units
  localparam int BIT_SLOW   = 326;   // about +2% bit time
  localparam int BIT_FAST   = 314;   // about -2% bit time

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic ack_auto = 1'b0;
  logic ack_man  = 1'b0;
  logic auto_en  = 1'b0;

  int total = 0;
  int bad   = 0;
  int lat   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic       pv = 1'b0;
  logic [7:0] pd = 8'h00;

  uart_rx_if u_if ();
  assign u_if.ack = ack_auto | ack_man;

  uart_rx #(
    .CLK_FREQ  (P_CLK_FREQ),
    .BAUD_RATE (P_BAUD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopv, input int per);
    @(posedge clk);
    #1 u_if.rx = 1'b0;
    #(per);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i];
      #(per);
    end
    u_if.rx = stopv;
    #(per);
  endtask

  // Sends a frame and counts clock edges from the start-bit fall to data_valid.
  task automatic send_measure(input logic [7:0] b, output int n_out);
    int n;
    n = 0;
    fork
      send_byte(b, 1'b1, BIT);
      begin
        @(posedge clk);
        while (n < 400) begin
          @(posedge clk);
          n++;
          #1;
          if (u_if.data_valid) break;
        end
      end
    join
    n_out = n;
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1 ack_man = 1'b1;
    @(posedge clk);
    #1 ack_man = 1'b0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reader model: acks one cycle after it sees a held byte.
  always @(negedge clk) begin
    ack_auto <= auto_en && rst_n && u_if.data_valid && !ack_auto;
  end

  // Scoreboard monitor: a new byte is a valid rise or a data change while valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.data_valid && (!pv || u_if.data != pd)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %h expected none", u_if.data);
        end else begin
          exp_b = exp_q.pop_front();
          check("rx_byte", {24'h0, u_if.data}, {24'h0, exp_b});
        end
      end
      pv <= u_if.data_valid;
      pd <= u_if.data;
    end else begin
      pv <= 1'b0;
      pd <= 8'h00;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    u_if.rx    = 1'b1;
    u_if.rx_en = 1'b1;

    // Reset with the line toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      u_if.rx = ~u_if.rx;
    end
    #1;
    check("rst_data",        {24'h0, u_if.data}, 32'h0);
    check("rst_data_valid",  {31'h0, u_if.data_valid}, 32'h0);
    check("rst_framing_err", {31'h0, u_if.framing_err}, 32'h0);
    check("rst_overrun_err", {31'h0, u_if.overrun_err}, 32'h0);
    check("rst_busy",        {31'h0, u_if.busy_flag}, 32'h0);
    u_if.rx = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_clks(5);

    // Single byte, latency, ack
    exp_q.push_back(8'hA5);
    send_measure(8'hA5, lat);
    check("latency_in_window", {31'h0, (lat >= 305 && lat <= 307)}, 32'h1);
    check("a5_data_valid", {31'h0, u_if.data_valid}, 32'h1);
    pulse_ack();
    #1;
    check("a5_acked_valid", {31'h0, u_if.data_valid}, 32'h0);

    // Short glitch on the line
    @(posedge clk);
    #1 u_if.rx = 1'b0;
    wait_clks(8);
    check("glitch_busy", {31'h0, u_if.busy_flag}, 32'h1);
    wait_clks(2);
    u_if.rx = 1'b1;
    wait_clks(30);
    check("glitch_idle",  {31'h0, u_if.busy_flag}, 32'h0);
    check("glitch_valid", {31'h0, u_if.data_valid}, 32'h0);
    check("glitch_flags", {30'h0, u_if.framing_err, u_if.overrun_err}, 32'h0);

    // Framing error, break, then recovery
    send_byte(8'h3C, 1'b0, BIT);
    wait_clks(64);
    check("break_framing_err", {31'h0, u_if.framing_err}, 32'h1);
    check("break_valid",       {31'h0, u_if.data_valid}, 32'h0);
    check("break_data",        {24'h0, u_if.data}, 32'hA5);
    check("break_busy",        {31'h0, u_if.busy_flag}, 32'h1);
    u_if.rx = 1'b1;
    wait_clks(5);
    check("break_exit_idle", {31'h0, u_if.busy_flag}, 32'h0);
    auto_en = 1'b1;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, BIT);
    wait_clks(20);
    check("recover_framing_cleared", {31'h0, u_if.framing_err}, 32'h0);
    check("recover_valid_acked",     {31'h0, u_if.data_valid}, 32'h0);

    // Overrun, then ack on the completion cycle
    auto_en = 1'b0;
    wait_clks(3);
    exp_q.push_back(8'h11);
    send_measure(8'h11, lat);
    exp_q.push_back(8'h22);
    send_byte(8'h22, 1'b1, BIT);
    wait_clks(5);
    check("overrun_flag",  {31'h0, u_if.overrun_err}, 32'h1);
    check("overrun_data",  {24'h0, u_if.data}, 32'h22);
    check("overrun_valid", {31'h0, u_if.data_valid}, 32'h1);
    pulse_ack();
    #1;
    check("overrun_ack_valid", {31'h0, u_if.data_valid}, 32'h0);
    check("overrun_ack_flag",  {31'h0, u_if.overrun_err}, 32'h0);
    exp_q.push_back(8'h33);
    send_byte(8'h33, 1'b1, BIT);
    exp_q.push_back(8'h44);
    fork
      send_byte(8'h44, 1'b1, BIT);
      begin
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1 ack_man = 1'b1;
        @(posedge clk);
        #1 ack_man = 1'b0;
      end
    join
    #1;
    check("same_cycle_valid",   {31'h0, u_if.data_valid}, 32'h1);
    check("same_cycle_data",    {24'h0, u_if.data}, 32'h44);
    check("same_cycle_overrun", {31'h0, u_if.overrun_err}, 32'h0);
    pulse_ack();

    // Back-to-back frames with baud error and rx_en dropped mid-frame
    auto_en = 1'b1;
    wait_clks(3);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1, BIT_SLOW);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b1, BIT_FAST);
    exp_q.push_back(8'h96);
    fork
      send_byte(8'h96, 1'b1, BIT_SLOW);
      begin
        #(BIT_SLOW * 5);
        u_if.rx_en = 1'b0;
      end
    join
    send_byte(8'h0F, 1'b1, BIT_FAST);
    wait_clks(2);
    check("disabled_not_busy", {31'h0, u_if.busy_flag}, 32'h0);
    wait_clks(8);
    u_if.rx_en = 1'b1;
    exp_q.push_back(8'hE1);
    send_byte(8'hE1, 1'b1, BIT);
    wait_clks(40);
    check("queue_empty", exp_q.size(), 32'h0);
    check("end_flags", {30'h0, u_if.framing_err, u_if.overrun_err}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
